decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; port names follow the codebase convention (clk, rst).
REQ-002 The block SHALL have the following parameters:
- XLEN, default 32: immediate output width, must be >= 12.
- SUPPORT_OPIMM, default 1: 1 decodes OP-IMM (0010011); 0 treats it as illegal.
- CNT_W, default 8: width of the illegal-instruction counter.
REQ-003 The block SHALL have the following ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  instr valid.
- in_ready  out  1  stage can accept.
- instr  in  32  instruction word.
- out_valid  out  1  decoded payload valid.
- out_ready  in  1  consumer accepts.
- rs1, rs2, rd  out  5 each  register indices.
- alu_op  out  4  ALU operation code.
- reg_write  out  1  rd write enable.
- use_imm  out  1  ALU operand B is imm.
- imm  out  XLEN  sign-extended immediate.
- illegal  out  1  instruction undecodable.
- cnt_clr  in  1  clear illegal counter.
- illegal_cnt  out  CNT_W  saturating count of illegal instructions delivered.

Function
REQ-004 alu_op codes SHALL be: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, INV=15.
REQ-005 R-type (opcode 0110011) SHALL decode as follows:
- funct3 000: funct7 0000000 gives ADD; funct7 0100000 gives SUB.
- funct3 001, 010, 011, 100, 110, 111: funct7 0000000 only, giving SLL, SLT, SLTU, XOR, OR, AND respectively.
- funct3 101: funct7 0000000 gives SRL; funct7 0100000 gives SRA.
- Legal R-type outputs: use_imm=0, imm=0.
REQ-006 OP-IMM (SUPPORT_OPIMM=1) SHALL decode as follows:
- funct3 000, 010, 011, 100, 110, 111 give ADD, SLT, SLTU, XOR, OR, AND respectively, with any instr[31:25].
- funct3 001 gives SLL only when instr[31:25]=0000000.
- funct3 101: instr[31:25]=0000000 gives SRL; 0100000 gives SRA.
- Legal OP-IMM outputs: use_imm=1, rs2=0, imm = instr[31:20] sign-extended to XLEN.
REQ-007 Every other encoding SHALL be illegal, producing illegal=1, alu_op=INV, reg_write=0, use_imm=0, imm=0.
- rs1, rs2 and rd SHALL still carry instr fields, except rs2=0 for OP-IMM.
REQ-008 Legal instructions SHALL drive illegal=0 and reg_write=1.
REQ-009 in_ready SHALL equal (!out_valid || out_ready), computed combinationally; a transfer occurs when in_valid && in_ready.
REQ-010 Decode latency SHALL be exactly 1 cycle: on a transfer, the decoded payload is registered and out_valid=1 on the following cycle.
REQ-011 While out_valid=1 and out_ready=0, every output payload field SHALL hold stable.
REQ-012 If out_valid && out_ready with no new transfer, out_valid SHALL clear next cycle.
- Simultaneous drain and accept SHALL yield back-to-back out_valid=1 with the new payload, one instruction per cycle, no bubble.
REQ-013 illegal_cnt SHALL increment by 1 on each output handshake (out_valid && out_ready) with illegal=1.
- It SHALL saturate at 2^CNT_W-1.
REQ-014 cnt_clr SHALL zero illegal_cnt next cycle; if cnt_clr coincides with an incrementing handshake, the result SHALL be 0.
REQ-015 The module SHALL hold no state besides the output register, out_valid and illegal_cnt.

Reset
REQ-016 On rst=1 at a clock edge, the following SHALL take effect:
- out_valid=0, illegal_cnt=0.
- rs1=rs2=rd=0, alu_op=INV, reg_write=0, use_imm=0, imm=0, illegal=0.
REQ-017 Reset mid-operation SHALL discard any held payload; no handshake SHALL count during reset.
REQ-018 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-019 ADD: instr=0x002081B3 with out_ready=1 -> next cycle out_valid=1, rs1=1, rs2=2, rd=3, alu_op=0, reg_write=1, use_imm=0, illegal=0.
REQ-020 ADDI/SRAI: 0xFFF00293 -> rd=5, rs1=0, rs2=0, alu_op=0, use_imm=1, imm=0xFFFFFFFF. 0x4030D093 -> alu_op=7, rd=1, imm=0x00000403.
REQ-021 Backpressure: accept 0x002081B3 with out_ready=0 for 3 cycles -> payload stable, in_ready=0; on release, accept 0xFFF00293 in the same cycle -> next cycle shows ADDI payload, out_valid=1.
REQ-022 Illegal/counter: 0x0000007F and 0xFE0081B3 each handshaked -> illegal=1, alu_op=15, reg_write=0, illegal_cnt=2. With CNT_W=2, 5 illegals -> illegal_cnt=3. cnt_clr coincident with an illegal handshake -> 0.
REQ-023 SUPPORT_OPIMM=0: 0xFFF00293 -> illegal=1, alu_op=15.
REQ-024 Reset while a payload is held -> next cycle out_valid=0, illegal_cnt=0, all outputs at REQ-016 values, in_ready=1 after release.

Source files
------------

// File: rtl/decode_stage.sv
// Single-stage RV32 ALU instruction decoder (R-type and optional OP-IMM) with a
// registered, backpressure-aware output and a saturating illegal-instruction counter.
module decode_stage #(
    parameter int XLEN          = 32,
    parameter bit SUPPORT_OPIMM = 1'b1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [3:0]       alu_op,
    output logic             reg_write,
    output logic             use_imm,
    output logic [XLEN-1:0]  imm,
    output logic             illegal,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_INV  = 4'd15;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    logic [4:0]      rs1_d, rs2_d, rd_d;
    logic [3:0]      alu_op_d;
    logic            legal_d, use_imm_d;
    logic [XLEN-1:0] imm_d;

    always_comb begin
        rs1_d     = instr[19:15];
        rs2_d     = instr[24:20];
        rd_d      = instr[11:7];
        alu_op_d  = ALU_INV;
        legal_d   = 1'b0;
        use_imm_d = 1'b0;
        imm_d     = '0;
        if (opcode == OPC_OP) begin
            legal_d = 1'b1;
            unique case (funct3)
                3'b000: begin
                    if (funct7 == F7_ZERO)     alu_op_d = ALU_ADD;
                    else if (funct7 == F7_ALT) alu_op_d = ALU_SUB;
                    else                       legal_d  = 1'b0;
                end
                3'b101: begin
                    if (funct7 == F7_ZERO)     alu_op_d = ALU_SRL;
                    else if (funct7 == F7_ALT) alu_op_d = ALU_SRA;
                    else                       legal_d  = 1'b0;
                end
                default: begin
                    legal_d = (funct7 == F7_ZERO);
                    unique case (funct3)
                        3'b001:  alu_op_d = ALU_SLL;
                        3'b010:  alu_op_d = ALU_SLT;
                        3'b011:  alu_op_d = ALU_SLTU;
                        3'b100:  alu_op_d = ALU_XOR;
                        3'b110:  alu_op_d = ALU_OR;
                        default: alu_op_d = ALU_AND;
                    endcase
                end
            endcase
        end else if (SUPPORT_OPIMM && opcode == OPC_OP_IMM) begin
            // rs2 is not an operand of OP-IMM, even when the shift encoding is bad.
            rs2_d   = 5'd0;
            legal_d = 1'b1;
            unique case (funct3)
                3'b000: alu_op_d = ALU_ADD;
                3'b010: alu_op_d = ALU_SLT;
                3'b011: alu_op_d = ALU_SLTU;
                3'b100: alu_op_d = ALU_XOR;
                3'b110: alu_op_d = ALU_OR;
                3'b111: alu_op_d = ALU_AND;
                3'b001: begin
                    if (funct7 == F7_ZERO) alu_op_d = ALU_SLL;
                    else                   legal_d  = 1'b0;
                end
                default: begin
                    if (funct7 == F7_ZERO)     alu_op_d = ALU_SRL;
                    else if (funct7 == F7_ALT) alu_op_d = ALU_SRA;
                    else                       legal_d  = 1'b0;
                end
            endcase
            if (legal_d) begin
                use_imm_d   = 1'b1;
                imm_d       = {XLEN{instr[31]}};
                imm_d[11:0] = instr[31:20];
            end
        end
        if (!legal_d) alu_op_d = ALU_INV;
    end

    // Handshake: a beat moves on a channel when valid && ready at a rising edge;
    // out_valid stays high and the payload frozen until out_ready accepts it.
    logic            out_valid_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;
    logic [3:0]      alu_op_q;
    logic            reg_write_q, use_imm_q, illegal_q;
    logic [XLEN-1:0] imm_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            in_fire, out_fire;

    assign in_ready = !out_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            alu_op_q    <= ALU_INV;
            reg_write_q <= 1'b0;
            use_imm_q   <= 1'b0;
            imm_q       <= '0;
            illegal_q   <= 1'b0;
        end else if (in_fire) begin
            out_valid_q <= 1'b1;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            alu_op_q    <= alu_op_d;
            reg_write_q <= legal_d;
            use_imm_q   <= use_imm_d;
            imm_q       <= imm_d;
            illegal_q   <= !legal_d;
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)                                       cnt_d = '0;
        else if (out_fire && illegal_q && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign out_valid   = out_valid_q;
    assign rs1         = rs1_q;
    assign rs2         = rs2_q;
    assign rd          = rd_q;
    assign alu_op      = alu_op_q;
    assign reg_write   = reg_write_q;
    assign use_imm     = use_imm_q;
    assign imm         = imm_q;
    assign illegal     = illegal_q;
    assign illegal_cnt = cnt_q;

endmodule
